// File: rtl/m_layer_input_buf.sv
// Layer-input replay buffer: captures one map, replays it NUM_LOOP times.
// Define LAYER_IN_PINGPONG_EN for two banks (fill one while replaying the other).
module m_layer_input_buf #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 36,
  parameter int ADDR_W   = 6,
  parameter int NUM_LOOP = 120,
  parameter int PULSE_AT = 30
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] map_in,
  input  logic              wr,
  input  logic              start,
  output logic [DATA_W-1:0] map_out,
  output logic              k_ready,
  output logic              k_loop,
  output logic              ready,
  output logic              done,
  output logic              full
);

  localparam int PW = (NUM_LOOP > 1) ? $clog2(NUM_LOOP) : 1;
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PULSE_A = ADDR_W'(PULSE_AT);
  localparam logic [PW-1:0]     LAST_P  = PW'(NUM_LOOP - 1);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic              state_q, state_d;
  logic [ADDR_W-1:0] addr_wr_q, addr_wr_d;
  logic [ADDR_W-1:0] addr_rd_q, addr_rd_d;
  logic [PW-1:0]     pass_q, pass_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] map_out_q, map_out_d;
  logic              k_ready_q, k_ready_d;
  logic              k_loop_q, k_loop_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              last_q, last_d;
  logic              wr_en, rd_en, start_ok, run_end;
  logic [DATA_W-1:0] rd_word;

`ifdef LAYER_IN_PINGPONG_EN
  logic              bank_q, bank_d;
  logic [DATA_W-1:0] mem [2][DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[bank_q][addr_wr_q] <= map_in;
  end

  assign rd_word = mem[~bank_q][addr_rd_q];
`else
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[addr_wr_q] <= map_in;
  end

  assign rd_word = mem[addr_rd_q];
`endif

  always_comb begin
    // k_ready still high means the last word is on map_out this cycle
    start_ok = (state_q == IDLE) && start && full_q && !k_ready_q;
    rd_en    = (state_q == RUN);
    run_end  = rd_en && (addr_rd_q == LAST_A) && (pass_q == LAST_P);
`ifdef LAYER_IN_PINGPONG_EN
    wr_en    = wr && !full_q;
    bank_d   = bank_q;
`else
    wr_en    = wr && !full_q && !rd_en;
`endif
    state_d   = state_q;
    addr_wr_d = addr_wr_q;
    addr_rd_d = addr_rd_q;
    pass_d    = pass_q;
    full_d    = full_q;

    if (wr_en) begin
      if (addr_wr_q == LAST_A) begin
        addr_wr_d = '0;
        full_d    = 1'b1;
      end else begin
        addr_wr_d = addr_wr_q + 1'b1;
      end
    end

    if (start_ok) begin
      state_d   = RUN;
      addr_rd_d = '0;
      pass_d    = '0;
`ifdef LAYER_IN_PINGPONG_EN
      bank_d    = ~bank_q;
      full_d    = 1'b0;
      addr_wr_d = '0;
`endif
    end

    if (rd_en) begin
      if (addr_rd_q == LAST_A) begin
        addr_rd_d = '0;
        pass_d    = pass_q + 1'b1;
      end else begin
        addr_rd_d = addr_rd_q + 1'b1;
      end
      if (run_end) begin
        state_d = IDLE;
        pass_d  = '0;
`ifndef LAYER_IN_PINGPONG_EN
        full_d  = 1'b0;
`endif
      end
    end

    k_ready_d = rd_en;
    k_loop_d  = rd_en && (addr_rd_q == PULSE_A);
    last_d    = run_end;
    done_d    = last_q;
    ready_d   = ~k_ready_q;
    map_out_d = rd_en ? rd_word : map_out_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_wr_q <= '0;
      addr_rd_q <= '0;
      pass_q    <= '0;
      full_q    <= 1'b0;
      map_out_q <= '0;
      k_ready_q <= 1'b0;
      k_loop_q  <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      last_q    <= 1'b0;
`ifdef LAYER_IN_PINGPONG_EN
      bank_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_wr_q <= addr_wr_d;
      addr_rd_q <= addr_rd_d;
      pass_q    <= pass_d;
      full_q    <= full_d;
      map_out_q <= map_out_d;
      k_ready_q <= k_ready_d;
      k_loop_q  <= k_loop_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      last_q    <= last_d;
`ifdef LAYER_IN_PINGPONG_EN
      bank_q    <= bank_d;
`endif
    end
  end

  assign map_out = map_out_q;
  assign k_ready = k_ready_q;
  assign k_loop  = k_loop_q;
  assign ready   = ready_q;
  assign done    = done_q;
  assign full    = full_q;

endmodule

// File: tb/tb_m_layer_input_buf.sv
// Directed bench for m_layer_input_buf: default 36x120 instance plus a
// 4-word single-pass instance.
module tb_m_layer_input_buf;

  logic        clk;
  logic        rst_n;
  logic [15:0] map_in, map_out;
  logic        wr, start, k_ready, k_loop, ready, done, full;
  logic [15:0] s_map_in, s_map_out;
  logic        s_wr, s_start, s_k_ready, s_k_loop, s_ready, s_done, s_full;
  int          n_tests = 0;
  int          n_fail  = 0;

  m_layer_input_buf dut (
    .clk_in(clk), .rst_n(rst_n), .map_in(map_in), .wr(wr),
    .start(start), .map_out(map_out), .k_ready(k_ready),
    .k_loop(k_loop), .ready(ready), .done(done), .full(full)
  );

  m_layer_input_buf #(
    .DATA_W(16), .DEPTH(4), .ADDR_W(2), .NUM_LOOP(1), .PULSE_AT(3)
  ) dut_s (
    .clk_in(clk), .rst_n(rst_n), .map_in(s_map_in), .wr(s_wr),
    .start(s_start), .map_out(s_map_out), .k_ready(s_k_ready),
    .k_loop(s_k_loop), .ready(s_ready), .done(s_done), .full(s_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    n_tests++;
    if ({map_out, k_ready, k_loop, ready, done, full} !== {16'h0, 5'b00100}) begin
      n_fail++;
      $display("FAIL reset_big: got %h/%b%b%b%b%b want 0000/00100",
               map_out, k_ready, k_loop, ready, done, full);
    end
    n_tests++;
    if ({s_map_out, s_k_ready, s_k_loop, s_ready, s_done, s_full} !== {16'h0, 5'b00100}) begin
      n_fail++;
      $display("FAIL reset_small: got %h/%b%b%b%b%b want 0000/00100",
               s_map_out, s_k_ready, s_k_loop, s_ready, s_done, s_full);
    end
  endtask

  task automatic test_ignored_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    n_tests++;
    if (k_ready !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_not_full: k_ready=%b ready=%b want 0 1", k_ready, ready);
    end
  endtask

  // Loads 36 words; start is also raised on the completing write and must be ignored.
  task automatic load(input int base);
    for (int i = 0; i < 36; i++) begin
      wr = 1'b1;
      map_in = 16'(base + i);
      start = (i == 35);
      tick;
    end
    wr = 1'b0;
    start = 1'b0;
    n_tests++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL load_full: full=%b want 1", full);
    end
  endtask

  // Starts at the current cycle T and checks the whole replay up to L+2.
  task automatic run_replay(input int base, input bit do_wr, input int wr_base);
    int derr, verr, rerr, kcnt, kerr;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_tests++;
    if (k_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_t1: k_ready=%b want 0", k_ready);
    end
    tick;
    for (int p = 0; p < 120; p++) begin
      derr = 0; verr = 0; rerr = 0; kcnt = 0; kerr = 0;
      for (int w = 0; w < 36; w++) begin
        if (map_out !== 16'(base + w)) derr++;
        if (k_ready !== 1'b1 || done !== 1'b0) verr++;
        if (ready !== ((p == 0 && w == 0) ? 1'b1 : 1'b0)) rerr++;
        if (k_loop === 1'b1) begin
          kcnt++;
          if (w != 30) kerr++;
        end
        start = (p == 5 && w == 3);
        wr = do_wr && (p == 0);
        map_in = 16'(wr_base + w);
        tick;
      end
      start = 1'b0;
      wr = 1'b0;
      n_tests++;
      if (derr != 0 || verr != 0 || rerr != 0) begin
        n_fail++;
        $display("FAIL replay_pass%0d: data_err=%0d valid_err=%0d ready_err=%0d want 0 0 0",
                 p, derr, verr, rerr);
      end
      n_tests++;
      if (kcnt != 1 || kerr != 0) begin
        n_fail++;
        $display("FAIL k_loop_pass%0d: pulses=%0d misplaced=%0d want 1 0", p, kcnt, kerr);
      end
    end
    n_tests++;
    if (k_ready !== 1'b0 || done !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL end_l1: k_ready=%b done=%b ready=%b want 0 1 0", k_ready, done, ready);
    end
    n_tests++;
`ifdef LAYER_IN_PINGPONG_EN
    if (full !== do_wr) begin
      n_fail++;
      $display("FAIL end_full: full=%b want %b", full, do_wr);
    end
`else
    if (full !== 1'b0) begin
      n_fail++;
      $display("FAIL end_full: full=%b want 0", full);
    end
`endif
  endtask

  task automatic test_replay;
    load(0);
    run_replay(0, 1'b1, 500);
`ifdef LAYER_IN_PINGPONG_EN
    run_replay(500, 1'b0, 0);
`else
    tick;
    n_tests++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL end_l2: ready=%b done=%b want 1 0", ready, done);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    n_tests++;
    if (k_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_no_refill: k_ready=%b want 0", k_ready);
    end
`endif
  endtask

  task automatic test_reset_mid;
    load(800);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    for (int i = 0; i < 57 * 36 + 10; i++) tick;
    n_tests++;
    if (k_ready !== 1'b1 || map_out !== 16'(800 + 10)) begin
      n_fail++;
      $display("FAIL mid_pass57: k_ready=%b map_out=%0d want 1 810", k_ready, map_out);
    end
    rst_n = 1'b0;
    tick;
    n_tests++;
    if ({map_out, k_ready, k_loop, ready, done, full} !== {16'h0, 5'b00100}) begin
      n_fail++;
      $display("FAIL reset_mid: got %h/%b%b%b%b%b want 0000/00100",
               map_out, k_ready, k_loop, ready, done, full);
    end
    rst_n = 1'b1;
    load(900);
    run_replay(900, 1'b0, 0);
  endtask

  task automatic test_small;
    logic [15:0] vals [4];
    vals[0] = 16'h8000; vals[1] = 16'hFFFF;
    vals[2] = 16'h0001; vals[3] = 16'h7FFF;
    for (int i = 0; i < 4; i++) begin
      s_wr = 1'b1;
      s_map_in = vals[i];
      tick;
    end
    s_wr = 1'b0;
    n_tests++;
    if (s_full !== 1'b1) begin
      n_fail++;
      $display("FAIL small_full: full=%b want 1", s_full);
    end
    s_start = 1'b1;
    tick;
    s_start = 1'b0;
    tick;
    for (int w = 0; w < 4; w++) begin
      n_tests++;
      if (s_map_out !== vals[w] || s_k_ready !== 1'b1 ||
          s_k_loop !== (w == 3) || s_done !== 1'b0) begin
        n_fail++;
        $display("FAIL small_word%0d: data=%h kr=%b kl=%b done=%b want %h 1 %b 0",
                 w, s_map_out, s_k_ready, s_k_loop, s_done, vals[w], (w == 3));
      end
      tick;
    end
    n_tests++;
    if (s_done !== 1'b1 || s_k_ready !== 1'b0 || s_full !== 1'b0) begin
      n_fail++;
      $display("FAIL small_done: done=%b kr=%b full=%b want 1 0 0",
               s_done, s_k_ready, s_full);
    end
    tick;
    n_tests++;
    if (s_ready !== 1'b1 || s_done !== 1'b0) begin
      n_fail++;
      $display("FAIL small_ready: ready=%b done=%b want 1 0", s_ready, s_done);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr = 1'b0; start = 1'b0; map_in = '0;
    s_wr = 1'b0; s_start = 1'b0; s_map_in = '0;
    test_reset;
    test_ignored_start;
    test_replay;
    test_reset_mid;
    test_small;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m_layer_input_buf.md
# m_layer_input_buf

Parametrised layer-input replay buffer for the convolution pipeline. Captures one flattened input map from the upstream layer into on-chip RAM at the producer's rate, then replays it NUM_LOOP times back-to-back to the kernel/MAC stage. It flags each pass with a `k_loop` pulse and holds the downstream stage in reset via `ready` while replay is active. It generalises the fixed 36-word / 120-pass layer-4 input buffer in width, depth, pass count and pulse position, and adds an explicit start handshake, a done pulse and optional ping-pong banking.

## Interface
- DATA_W, 16, map word width (signed)
- DEPTH, 36, words per input map; must be ≥ 2
- ADDR_W, 6, address width; must satisfy 2^ADDR_W ≥ DEPTH
- NUM_LOOP, 120, replay passes per start; must be ≥ 1
- PULSE_AT, 30, word index within a pass at which `k_loop` fires; must be < DEPTH
- clk_in  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- map_in  in  DATA_W  signed input word
- wr  in  1  write strobe for map_in
- start  in  1  request replay; sampled only in IDLE
- map_out  out  DATA_W  signed replayed word
- k_ready  out  1  map_out valid / replay active; acts as enable for the kernel stage
- k_loop  out  1  one-cycle pass marker
- ready  out  1  active-low reset for the next stage; registered ~k_ready
- done  out  1  one-cycle pulse after the final word of the final pass
- full  out  1  fill bank holds DEPTH words

## Operation
- Write side: `addr_wr` advances on each accepted `wr` and wraps DEPTH-1→0. The write that lands at DEPTH-1 sets `full`. A `wr` is dropped, with no address change, while `full`=1, or in single-bank mode while the FSM is in RUN.
- FSM states: IDLE, RUN.
  - IDLE→RUN on `start`=1 and `full`=1. Otherwise `start` is ignored, including in RUN.
  - RUN: `addr_rd` counts 0..DEPTH-1 and wraps. `pass_cnt` increments on each wrap.
  - RUN→IDLE on the cycle the read address DEPTH-1 is issued with `pass_cnt`=NUM_LOOP-1.
- Single-bank mode: `full` clears on RUN→IDLE. The same map cannot be replayed twice without a refill.
- RAM: simple dual-port, one-cycle registered read. `map_out` holds its last value when not reading.
- `k_loop` is 1 for exactly one cycle per pass, in the cycle `map_out` carries word PULSE_AT. This gives NUM_LOOP pulses per start.
- No arithmetic. Data passes bit-exact, with no sign handling beyond width.

## Timing
- Reset values: map_out=0, k_ready=0, k_loop=0, ready=1, done=0, full=0, state IDLE, all counters 0.
- Start sampled at cycle T:
  - RUN from T+1 with address 0.
  - Word 0 appears on `map_out` with `k_ready`=1 at T+2.
  - `ready` falls at T+3.
- Words are contiguous: DEPTH×NUM_LOOP consecutive valid cycles, with no gap between passes.
- Last word at cycle L:
  - `k_ready` falls at L+1.
  - `done`=1 at L+1.
  - `ready` rises at L+2.
  - A new `start` is accepted from L+1 if `full`=1.
- A write completing `full` at cycle W allows `start` to be accepted from W+1, not at W.
- Reset mid-operation applies at the next edge: all outputs return to reset values, `full` clears, and RAM contents are undefined for reuse.

## Configuration
- LAYER_IN_PINGPONG_EN defined:
  - Two RAM banks of DEPTH words each. Writes target the fill bank and replay reads the other.
  - On start acceptance the banks swap, `full` clears, and `addr_wr` is 0.
  - `wr` is accepted during RUN, so the next map loads while the current one replays.
  - `full` is not cleared on RUN→IDLE.
- LAYER_IN_PINGPONG_EN undefined: one bank, single-bank rules above. RAM usage is half that of ping-pong mode.

## Test plan
- Defaults. Write 36 words 0..35, then `start` → words 0..35 repeated 120 times (4320 valid cycles). `k_loop` fires 120 times, each aligned with word 30. `done` fires once, after the last word 35.
- `start` with `full`=0, or `start` during RUN → ignored. No change to `k_ready` or the pass count.
- Single-bank: `wr` bursts during RUN → dropped. Replayed data unchanged. `full`=0 after done.
- Ping-pong: load map A, start, load map B during replay, start at L+1 → B's word 0 at L+3. No corruption of A.
- `rst_n`=0 mid-pass 57 → next cycle k_ready=0, ready=1, full=0. A fresh write+start replays correctly.
- DEPTH=4, NUM_LOOP=1, PULSE_AT=3 → 4 words, single `k_loop` on word 3, `done` the following cycle.
